// File: rtl/unsharp_mask_sched.sv
// Job-level scheduler for the HLS unsharp-mask core (ap_ctrl_hs): runs N frames with host swap windows between them.
// Define UNSHARP_SCHED_PERF_EN to build the per-frame latency counter driving last_cycles.
module unsharp_mask_sched #(
    parameter int               CNT_W          = 8,
    parameter int               TMO_W          = 24,
    parameter logic [TMO_W-1:0] TIMEOUT_CYCLES = 24'd1000000,
    parameter int               PERF_W         = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              job_valid,
    output logic              job_ready,
    input  logic [CNT_W-1:0]  job_count,
    output logic              busy,
    output logic [CNT_W-1:0]  frame_idx,
    output logic              frame_done,
    output logic              job_done,
    output logic              host_mem_en,
    input  logic              host_mem_ack,
    output logic              err_timeout,
    input  logic              err_clr,
    output logic [PERF_W-1:0] last_cycles,
    output logic              ap_start,
    input  logic              ap_done,
    input  logic              ap_ready,
    input  logic              ap_idle
);

    typedef enum logic [2:0] {
        IDLE,
        WAIT_IDLE,
        START,
        RUN,
        SWAP,
        FIN
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [TMO_W-1:0] wd_cnt;
    logic [TMO_W-1:0] wd_inc;
    logic             active;
    logic             frame_cmpl;
    logic             wd_fire;
    logic             last_frame;

    assign active     = (state == START) || (state == RUN);
    // A core that raises ap_ready and ap_done together finishes the frame while still in START.
    assign frame_cmpl = ((state == START) && ap_ready && ap_done) || ((state == RUN) && ap_done);
    assign wd_inc     = (&wd_cnt) ? wd_cnt : wd_cnt + TMO_W'(1);
    assign wd_fire    = (TIMEOUT_CYCLES != '0) && active && !frame_cmpl && (wd_inc == TIMEOUT_CYCLES);
    assign last_frame = (frame_idx == cnt - CNT_W'(1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (job_valid) begin
                    state_nxt = (job_count == '0) ? FIN : WAIT_IDLE;
                end
            end
            WAIT_IDLE: begin
                if (ap_idle) begin
                    state_nxt = START;
                end
            end
            START, RUN: begin
                if (frame_cmpl) begin
                    state_nxt = last_frame ? FIN : SWAP;
                end else if (wd_fire) begin
                    state_nxt = FIN;
                end else if ((state == START) && ap_ready) begin
                    state_nxt = RUN;
                end
            end
            SWAP: begin
                if (host_mem_ack) begin
                    state_nxt = WAIT_IDLE;
                end
            end
            FIN: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // IDLE-owned outputs are masked by rst so asserting reset forces every output low at once.
    always_comb begin
        job_ready   = 1'b0;
        host_mem_en = 1'b0;
        ap_start    = 1'b0;
        job_done    = 1'b0;
        busy        = 1'b1;
        case (state)
            IDLE: begin
                job_ready   = rst;
                host_mem_en = rst;
                busy        = 1'b0;
            end
            START: begin
                ap_start = 1'b1;
            end
            SWAP: begin
                host_mem_en = 1'b1;
            end
            FIN: begin
                job_done = 1'b1;
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt         <= '0;
            frame_idx   <= '0;
            frame_done  <= 1'b0;
            err_timeout <= 1'b0;
            wd_cnt      <= '0;
        end else begin
            frame_done <= frame_cmpl;
            if ((state == IDLE) && job_valid) begin
                cnt       <= job_count;
                frame_idx <= '0;
            end else if ((state == SWAP) && host_mem_ack) begin
                frame_idx <= frame_idx + CNT_W'(1);
            end
            wd_cnt <= active ? wd_inc : '0;
            if (wd_fire) begin
                err_timeout <= 1'b1;
            end else if (err_clr) begin
                err_timeout <= 1'b0;
            end
        end
    end

`ifdef UNSHARP_SCHED_PERF_EN
    logic [PERF_W-1:0] perf_cnt;
    logic [PERF_W-1:0] perf_inc;

    // perf_inc already includes the current cycle, so the ap_done cycle is counted.
    assign perf_inc = (&perf_cnt) ? perf_cnt : perf_cnt + PERF_W'(1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_cnt    <= '0;
            last_cycles <= '0;
        end else begin
            perf_cnt <= active ? perf_inc : '0;
            if (frame_cmpl) begin
                last_cycles <= perf_inc;
            end
        end
    end
`else
    assign last_cycles = '0;
`endif

endmodule

// File: tb/tb_unsharp_mask_sched.sv
// Directed bench for unsharp_mask_sched: scripted core/host responders plus a linear sequence of checked steps.
module tb_unsharp_mask_sched;

    logic        clk;
    logic        rst;
    logic        job_valid;
    logic        job_ready;
    logic [7:0]  job_count;
    logic        busy;
    logic [7:0]  frame_idx;
    logic        frame_done;
    logic        job_done;
    logic        host_mem_en;
    logic        host_mem_ack;
    logic        err_timeout;
    logic        err_clr;
    logic [31:0] last_cycles;
    logic        ap_start;
    logic        ap_done;
    logic        ap_ready;
    logic        ap_idle;

    int total = 0;
    int bad   = 0;

    int rdy_at  = 3;
    int done_at = 13;
    int core_t  = 0;
    int host_t  = 0;
    int hs_cnt  = 0;
    int st_cnt  = 0;
    int fd_cnt  = 0;
    int jd_cnt  = 0;
    int sw_cnt  = 0;
    int bz_cnt  = 0;
    int fidx_log[16];

`ifdef UNSHARP_SCHED_PERF_EN
    localparam int EXP_LAT_NORMAL = 13;
    localparam int EXP_LAT_COMB   = 1;
`else
    localparam int EXP_LAT_NORMAL = 0;
    localparam int EXP_LAT_COMB   = 0;
`endif

    unsharp_mask_sched #(
        .CNT_W         (8),
        .TMO_W         (24),
        .TIMEOUT_CYCLES(24'd50),
        .PERF_W        (32)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .job_valid   (job_valid),
        .job_ready   (job_ready),
        .job_count   (job_count),
        .busy        (busy),
        .frame_idx   (frame_idx),
        .frame_done  (frame_done),
        .job_done    (job_done),
        .host_mem_en (host_mem_en),
        .host_mem_ack(host_mem_ack),
        .err_timeout (err_timeout),
        .err_clr     (err_clr),
        .last_cycles (last_cycles),
        .ap_start    (ap_start),
        .ap_done     (ap_done),
        .ap_ready    (ap_ready),
        .ap_idle     (ap_idle)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Core and host responders; they also tally handshakes and pulses for the checks below.
    always @(negedge clk) begin
        if (!busy) begin
            core_t = 0;
        end else if (core_t == 0) begin
            if (ap_start) core_t = 1;
        end else begin
            core_t = core_t + 1;
        end
        ap_ready = (core_t != 0) && (core_t == rdy_at);
        ap_done  = (core_t != 0) && (core_t == done_at);
        if (ap_start && ap_ready) hs_cnt = hs_cnt + 1;
        if (ap_start) st_cnt = st_cnt + 1;
        if (ap_done) core_t = 0;
        if (host_mem_en && busy) begin
            host_t = host_t + 1;
            if (host_t == 1) sw_cnt = sw_cnt + 1;
            host_mem_ack = (host_t == 4);
        end else begin
            host_t = 0;
            host_mem_ack = 1'b0;
        end
        if (frame_done) begin
            fidx_log[fd_cnt % 16] = int'(frame_idx);
            fd_cnt = fd_cnt + 1;
        end
        if (job_done) jd_cnt = jd_cnt + 1;
        if (busy) bz_cnt = bz_cnt + 1;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total = total + 1;
        assert (obs === exp) else begin
            bad = bad + 1;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input int count);
        job_valid = 1'b1;
        job_count = 8'(count);
        tick(1);
        job_valid = 1'b0;
    endtask

    task automatic waitJobDone(input string tag, input int limit);
        int start;
        start = jd_cnt;
        for (int i = 0; i < limit; i++) begin
            tick(1);
            if (jd_cnt != start) break;
        end
        checkOutput(tag, jd_cnt - start, 1);
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL global_timeout");
        $fatal(1, "[TB] simulation did not finish");
    end

    initial begin
        int hs0, st0, fd0, jd0, sw0, bz0;
        logic stuck;

        rst = 1'b1; job_valid = 1'b0; job_count = '0; err_clr = 1'b0; ap_idle = 1'b1;
        #2 rst = 1'b0;
        #1;
        checkOutput("rst_job_ready", job_ready, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_host_mem_en", host_mem_en, 0);
        checkOutput("rst_ap_start", ap_start, 0);
        checkOutput("rst_err_timeout", err_timeout, 0);
        checkOutput("rst_frame_idx", frame_idx, 0);
        checkOutput("rst_last_cycles", last_cycles, 0);
        tick(2);
        rst = 1'b1;
        #1;
        checkOutput("rel_job_ready", job_ready, 1);
        checkOutput("rel_host_mem_en", host_mem_en, 1);

        $display("[TB] three-frame job");
        hs0 = hs_cnt; st0 = st_cnt; fd0 = fd_cnt; sw0 = sw_cnt;
        applyStimulus(3);
        checkOutput("a_busy", busy, 1);
        waitJobDone("a_job_done", 300);
        checkOutput("a_handshakes", hs_cnt - hs0, 3);
        checkOutput("a_start_cycles", st_cnt - st0, 9);
        checkOutput("a_frame_done", fd_cnt - fd0, 3);
        checkOutput("a_swaps", sw_cnt - sw0, 2);
        for (int i = 0; i < 3; i++) begin
            checkOutput($sformatf("a_frame_idx_%0d", i), fidx_log[(fd0 + i) % 16], i);
        end
        checkOutput("a_last_cycles", last_cycles, EXP_LAT_NORMAL);
        tick(1);
        checkOutput("a_idle_busy", busy, 0);
        checkOutput("a_idle_job_ready", job_ready, 1);
        checkOutput("a_idle_frame_idx", frame_idx, 2);

        $display("[TB] empty job");
        st0 = st_cnt; bz0 = bz_cnt;
        applyStimulus(0);
        checkOutput("b_job_done", job_done, 1);
        checkOutput("b_busy_fin", busy, 1);
        tick(1);
        checkOutput("b_job_done_low", job_done, 0);
        checkOutput("b_busy_idle", busy, 0);
        checkOutput("b_busy_cycles", bz_cnt - bz0, 1);
        checkOutput("b_no_start", st_cnt - st0, 0);

        $display("[TB] combinational core");
        rdy_at = 1; done_at = 1;
        hs0 = hs_cnt; st0 = st_cnt; fd0 = fd_cnt;
        applyStimulus(2);
        waitJobDone("c_job_done", 200);
        checkOutput("c_start_cycles", st_cnt - st0, 2);
        checkOutput("c_handshakes", hs_cnt - hs0, 2);
        checkOutput("c_frame_done", fd_cnt - fd0, 2);
        checkOutput("c_last_cycles", last_cycles, EXP_LAT_COMB);
        tick(1);

        $display("[TB] watchdog");
        rdy_at = 3; done_at = 0;
        fd0 = fd_cnt; jd0 = jd_cnt;
        applyStimulus(4);
        tick(1);
        checkOutput("d_ap_start", ap_start, 1);
        tick(49);
        checkOutput("d_err_before", err_timeout, 0);
        tick(1);
        checkOutput("d_err_fired", err_timeout, 1);
        checkOutput("d_job_done", job_done, 1);
        checkOutput("d_ap_start_low", ap_start, 0);
        tick(1);
        checkOutput("d_idle", busy, 0);
        checkOutput("d_no_frame_done", fd_cnt - fd0, 0);
        checkOutput("d_one_job_done", jd_cnt - jd0, 1);
        err_clr = 1'b1;
        tick(1);
        err_clr = 1'b0;
        checkOutput("d_err_cleared", err_timeout, 0);
        applyStimulus(1);
        tick(1);
        tick(49);
        err_clr = 1'b1;
        tick(1);
        err_clr = 1'b0;
        checkOutput("d_set_beats_clr", err_timeout, 1);
        tick(1);
        err_clr = 1'b1;
        tick(1);
        err_clr = 1'b0;
        checkOutput("d_err_cleared2", err_timeout, 0);

        $display("[TB] reset mid-run");
        rdy_at = 3; done_at = 13;
        applyStimulus(4);
        for (int i = 0; i < 200; i++) begin
            if ((frame_idx == 8'd1) && ap_start) break;
            tick(1);
        end
        checkOutput("e_frame1_start", {frame_idx, 7'd0, ap_start}, {8'd1, 7'd0, 1'b1});
        tick(3);
        checkOutput("e_in_run", {busy, ap_start}, 2'b10);
        fd0 = fd_cnt; jd0 = jd_cnt;
        rst = 1'b0;
        #1;
        checkOutput("e_rst_busy", busy, 0);
        checkOutput("e_rst_ap_start", ap_start, 0);
        checkOutput("e_rst_host_mem_en", host_mem_en, 0);
        checkOutput("e_rst_job_ready", job_ready, 0);
        tick(2);
        checkOutput("e_no_pulses", {fd_cnt - fd0, jd_cnt - jd0}, 0);
        rst = 1'b1;
        #1;
        checkOutput("e_rel_job_ready", job_ready, 1);
        hs0 = hs_cnt; fd0 = fd_cnt;
        applyStimulus(1);
        waitJobDone("e_job_done", 200);
        checkOutput("e_frame_done", fd_cnt - fd0, 1);
        checkOutput("e_handshakes", hs_cnt - hs0, 1);
        checkOutput("e_frame_idx", frame_idx, 0);
        tick(1);

        $display("[TB] ap_idle stall");
        ap_idle = 1'b0;
        applyStimulus(1);
        stuck = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick(1);
            stuck = stuck | ap_start;
        end
        checkOutput("f_no_start_while_busy_core", stuck, 0);
        ap_idle = 1'b1;
        tick(1);
        checkOutput("f_start_after_idle", ap_start, 1);
        waitJobDone("f_job_done", 200);
        tick(1);
        checkOutput("f_back_idle", busy, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/unsharp_mask_sched.md
Name: unsharp_mask_sched

Overview:
- Job-level scheduler for the HLS unsharp-mask core's ap_ctrl_hs interface.
- Accepts a job of N frames from the host and sequences N back-to-back core runs.
- Between frames, grants the host an exclusive memory-swap window so img/mask_img/kernelData buffers are reloaded while the core is idle.
- Includes a per-frame watchdog and a frame-latency counter.

Parameters:
- CNT_W, 8, width of job_count and frame_idx.
- TMO_W, 24, width of the watchdog counter.
- TIMEOUT_CYCLES, 24'd1000000, max cycles from ap_start assertion to ap_done before abort; 0 disables the watchdog.
- PERF_W, 32, width of last_cycles.

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  asynchronous, active-low reset (0 = reset asserted).
- job_valid  in  1  host offers a job.
- job_ready  out  1  scheduler can accept a job (state IDLE).
- job_count  in  CNT_W  frames in job; sampled when job_valid && job_ready.
- busy  out  1  job in progress (any state except IDLE).
- frame_idx  out  CNT_W  index of the current frame, 0-based.
- frame_done  out  1  1-cycle pulse per completed frame.
- job_done  out  1  1-cycle pulse at job end; also pulses on abort.
- host_mem_en  out  1  host owns the accelerator memories (swap window).
- host_mem_ack  in  1  host finished the swap; valid only while host_mem_en=1.
- err_timeout  out  1  sticky; watchdog fired.
- err_clr  in  1  clears err_timeout.
- last_cycles  out  PERF_W  ap_start-to-ap_done latency of the last frame.
- ap_start  out  1  to core.
- ap_done  in  1  from core.
- ap_ready  in  1  from core.
- ap_idle  in  1  from core.

Behaviour:
- Reset values: job_ready=0 during reset, 1 in the first cycle after release; all other outputs 0; state IDLE.
- States: IDLE, WAIT_IDLE, START, RUN, SWAP, FIN.
- IDLE:
  - job_ready=1, host_mem_en=1 (the host owns memory while no job is active).
  - On job_valid: latch job_count into cnt and set frame_idx=0.
  - cnt==0 -> FIN, so job_done pulses next cycle and the core never starts.
  - Otherwise -> WAIT_IDLE.
- WAIT_IDLE: host_mem_en=0; wait for ap_idle=1 -> START.
- START:
  - ap_start=1; hold until ap_ready=1, then drop ap_start the next cycle.
  - Watchdog and latency counters clear on entry and count from the first ap_start cycle.
  - If ap_done=1 in the same cycle as ap_ready: treat the frame as complete and go directly to the frame-complete action.
  - Otherwise -> RUN.
- RUN: ap_start=0; on ap_done=1, perform the frame-complete action.
- Frame-complete action:
  - frame_done pulses the following cycle; last_cycles updates.
  - If frame_idx==cnt-1 -> FIN.
  - Else -> SWAP.
- SWAP:
  - host_mem_en=1; wait for host_mem_ack=1.
  - Then frame_idx+=1 and host_mem_en drops the same edge -> WAIT_IDLE.
  - host_mem_ack outside SWAP/IDLE is ignored.
- FIN: job_done=1 for one cycle -> IDLE.
- Watchdog:
  - Active in START and RUN when TIMEOUT_CYCLES!=0; the counter saturates and never wraps.
  - When the count reaches TIMEOUT_CYCLES: err_timeout=1, ap_start=0, -> FIN (job_done pulses, frame_done does not).
- err_clr: err_timeout cleared by err_clr; set takes priority over a simultaneous clear.
- frame_idx: holds its last value in IDLE until the next job is accepted.
- Reset mid-job: immediate return to IDLE; ap_start drops asynchronously and no done pulses are emitted.
- ap_done is ignored outside START/RUN.
- job_count=2^CNT_W-1 is legal; frame_idx never wraps within a job.

Optional Feature:
- Macro UNSHARP_SCHED_PERF_EN.
- Defined:
  - last_cycles counts cycles from the first ap_start=1 cycle through the ap_done cycle inclusive, saturating at all-ones.
  - last_cycles latches at frame completion.
- Undefined: last_cycles tied to 0 and the counter logic is absent; the port is still present.

Test Plan:
- Core model: ap_ready 2 cycles after ap_start, ap_done 10 cycles later.
  - Stimulus: job_count=3; host_mem_ack 4 cycles after each host_mem_en rise.
  - Required: exactly 3 ap_start handshakes, 3 frame_done pulses, frame_idx 0,1,2, 2 swap windows, then job_done; last_cycles=13 with PERF_EN.
- job_count=0 -> job_done 1 cycle after acceptance; ap_start never asserted; busy high for exactly 1 cycle (FIN).
- Combinational-style core (ap_ready and ap_done both in the first ap_start cycle), job_count=2 -> ap_start high exactly 1 cycle per frame; 2 frame_done pulses.
- TIMEOUT_CYCLES=50, core never asserts ap_done -> err_timeout=1 at cycle 50 after ap_start, job_done pulses, no frame_done, state IDLE.
  - err_clr then clears the flag; an err_clr in the same cycle as a fresh timeout leaves err_timeout=1.
- rst driven low mid-RUN on frame 1 of 4 -> ap_start, busy, host_mem_en = 0 without waiting for a clock edge.
  - After release: job_ready=1 and a new job_count=1 runs normally.
- ap_idle held 0 for 20 cycles in WAIT_IDLE -> ap_start stays 0 until ap_idle=1, then asserts on the next cycle.
